// File: rtl/warmboot_sched_if.sv
// Request/grant and SB_WARMBOOT drive bundle between application requesters and warmboot_sched.
// Handshake: a requester holds REQ[i] high (level) until it sees GNT[i]; GNT is one-hot and stays high until abort or reset.
interface warmboot_sched_if #(
  parameter int NREQ = 4
);
  logic                ENABLE;
  logic [NREQ-1:0]     REQ;
  logic [2*NREQ-1:0]   REQ_IMG;
  logic                ABORT;
  logic [NREQ-1:0]     GNT;
  logic                BUSY;
  logic                LED_STATUS;
  logic                WB_BOOT;
  logic                WB_S1;
  logic                WB_S0;
  logic [1:0]          STATE_DBG;

  modport master (
    output ENABLE, REQ, REQ_IMG, ABORT,
    input  GNT, BUSY, LED_STATUS, WB_BOOT, WB_S1, WB_S0, STATE_DBG
  );

  modport slave (
    input  ENABLE, REQ, REQ_IMG, ABORT,
    output GNT, BUSY, LED_STATUS, WB_BOOT, WB_S1, WB_S0, STATE_DBG
  );
endinterface

// File: rtl/warmboot_sched.sv
// Round-robin warm-reboot arbiter: grants one requester, latches its image select,
// runs an abortable countdown with LED blink, then pulses SB_WARMBOOT.BOOT.
module warmboot_sched #(
  parameter int NREQ       = 4,
  parameter int DELAY_LOG2 = 22,
  parameter int BOOT_HOLD  = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  warmboot_sched_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DELAY_LOG2 > 4) ? DELAY_LOG2 : 4;
  localparam logic [CW-1:0] HOLD_LAST = CW'(BOOT_HOLD - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_BOOT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            cd_run;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            led;
  logic            wb_boot;
  logic            wb_s1;
  logic            wb_s0;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [1:0]      win_img;
  logic [PW-1:0]   ptr_next;
  logic [CW-1:0]   cnt_step;
  int              cand;

  // Scan from ptr upwards, wrapping, and take the first requester found.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!win_found && bus.REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  assign win_onehot = NREQ'(1) << win_idx;
  assign win_img    = bus.REQ_IMG[2*int'(win_idx) +: 2];
  assign ptr_next   = (win_idx == PTR_LAST) ? '0 : win_idx + PW'(1);

  // The first countdown cycle holds the counter at zero, so BOOT rises
  // 2^DELAY_LOG2+1 edges after the winning request was sampled.
  assign cnt_step   = cd_run ? cnt + CW'(1) : cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      cd_run  <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      led     <= 1'b0;
      wb_boot <= 1'b0;
      wb_s1   <= 1'b0;
      wb_s0   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ENABLE && win_found) begin
            gnt            <= win_onehot;
            {wb_s1, wb_s0} <= win_img;
            ptr            <= ptr_next;
            cnt            <= '0;
            cd_run         <= 1'b0;
            busy           <= 1'b1;
            led            <= 1'b0;
            state          <= S_COUNT;
          end else begin
            gnt <= '0;
          end
        end
        S_COUNT: begin
          if (bus.ABORT || !bus.ENABLE) begin
            gnt   <= '0;
            busy  <= 1'b0;
            led   <= 1'b0;
            wb_s1 <= 1'b0;
            wb_s0 <= 1'b0;
            state <= S_IDLE;
          end else if (&cnt[DELAY_LOG2-1:0]) begin
            wb_boot <= 1'b1;
            cnt     <= '0;
            state   <= S_BOOT;
          end else begin
            cnt    <= cnt_step;
            cd_run <= 1'b1;
            led    <= cnt_step[DELAY_LOG2-2];
          end
        end
        S_BOOT: begin
          if (cnt == HOLD_LAST) begin
            wb_boot <= 1'b0;
            led     <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          wb_boot <= 1'b0;
          led     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.GNT        = gnt;
  assign bus.BUSY       = busy;
  assign bus.LED_STATUS = led;
  assign bus.WB_BOOT    = wb_boot;
  assign bus.WB_S1      = wb_s1;
  assign bus.WB_S0      = wb_s0;
  assign bus.STATE_DBG  = state;

endmodule

// File: tb/tb_warmboot_sched.sv
// Directed bench for warmboot_sched: expected output vectors are queued per step and
// compared against the outputs sampled 1 time unit after each rising edge.
module tb_warmboot_sched;

  localparam int NREQ  = 4;
  localparam int DL    = 4;
  localparam int HOLD  = 3;
  localparam int OW    = NREQ + 5;
  localparam int CD    = 1 << DL;

  logic CLK;
  logic RST_N;

  warmboot_sched_if #(.NREQ(NREQ)) bus ();

  warmboot_sched #(
    .NREQ      (NREQ),
    .DELAY_LOG2(DL),
    .BOOT_HOLD (HOLD)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  function automatic logic [OW-1:0] obs();
    return {bus.GNT, bus.BUSY, bus.LED_STATUS, bus.WB_BOOT, bus.WB_S1, bus.WB_S0};
  endfunction

  function automatic logic [OW-1:0] mk(input logic [NREQ-1:0] g, input logic busy,
                                       input logic led, input logic boot,
                                       input logic s1, input logic s0);
    return {g, busy, led, boot, s1, s0};
  endfunction

  // Expected outputs j edges after the grant edge of an uninterrupted run.
  function automatic logic [OW-1:0] run_vec(input logic [NREQ-1:0] g, input logic s1,
                                            input logic s0, input int j);
    int c;
    if (j == 0) return mk(g, 1'b1, 1'b0, 1'b0, s1, s0);
    if (j <= CD) begin
      c = j - 1;
      return mk(g, 1'b1, ((c >> (DL - 2)) & 1) != 0, 1'b0, s1, s0);
    end
    if (j <= CD + HOLD) return mk(g, 1'b1, 1'b1, 1'b1, s1, s0);
    return mk(g, 1'b1, 1'b1, 1'b0, s1, s0);
  endfunction

  task automatic check(input string tag);
    logic [OW-1:0] e;
    logic [OW-1:0] o;
    chk_cnt++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL %s observed=%b expected=<empty queue>", tag, obs());
    end else begin
      e = exp_q.pop_front();
      o = obs();
      assert (o === e) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_checks(input int n, input string tag);
    for (int j = 0; j < n; j++) exp_q.push_back('0);
    for (int j = 0; j < n; j++) begin
      tick();
      check($sformatf("%s_%0d", tag, j));
    end
  endtask

  task automatic follow(input logic [NREQ-1:0] g, input logic s1, input logic s0,
                        input int j0, input int j1, input string tag);
    for (int j = j0; j < j1; j++) exp_q.push_back(run_vec(g, s1, s0, j));
    for (int j = j0; j < j1; j++) begin
      tick();
      check($sformatf("%s_%0d", tag, j));
    end
  endtask

  task automatic do_reset(input string tag);
    RST_N       = 1'b0;
    bus.ENABLE  = 1'b0;
    bus.REQ     = '0;
    bus.REQ_IMG = '0;
    bus.ABORT   = 1'b0;
    #1;
    exp_q.push_back('0);
    check(tag);
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N       = 1'b0;
    bus.ENABLE  = 1'b0;
    bus.REQ     = '0;
    bus.REQ_IMG = '0;
    bus.ABORT   = 1'b0;
    tick();

    // 1: idle with no requests
    do_reset("t1_rst");
    bus.ENABLE = 1'b1;
    idle_checks(20, "t1_idle");

    // 2: single request, full run to DONE; later REQ/IMG/ABORT/ENABLE changes ignored
    do_reset("t2_rst");
    bus.ENABLE  = 1'b1;
    bus.REQ_IMG = 8'b01_10_11_00;
    bus.REQ     = 4'b0100;
    follow(4'b0100, 1'b1, 1'b0, 0, 1, "t2");
    bus.REQ     = 4'b1011;
    bus.REQ_IMG = 8'h00;
    follow(4'b0100, 1'b1, 1'b0, 1, CD + HOLD, "t2");
    bus.ABORT   = 1'b1;
    follow(4'b0100, 1'b1, 1'b0, CD + HOLD, CD + HOLD + 3, "t2_boot_abort");
    bus.ABORT   = 1'b0;
    bus.ENABLE  = 1'b0;
    follow(4'b0100, 1'b1, 1'b0, CD + HOLD + 3, CD + HOLD + 8, "t2_done");

    // 3: round robin with aborts at counter 5
    do_reset("t3_rst");
    bus.ENABLE  = 1'b1;
    bus.REQ_IMG = 8'b01_10_11_00;
    bus.REQ     = 4'b1010;
    follow(4'b0010, 1'b1, 1'b1, 0, 7, "t3_a");
    bus.ABORT = 1'b1;
    idle_checks(1, "t3_abort1");
    bus.ABORT = 1'b0;
    follow(4'b1000, 1'b0, 1'b1, 0, 7, "t3_b");
    bus.ABORT = 1'b1;
    idle_checks(1, "t3_abort2");
    bus.ABORT = 1'b0;
    follow(4'b0010, 1'b1, 1'b1, 0, 3, "t3_wrap");

    // 4: abort on terminal count beats BOOT
    do_reset("t4_rst");
    bus.ENABLE  = 1'b1;
    bus.REQ_IMG = 8'b00_00_00_11;
    bus.REQ     = 4'b0001;
    follow(4'b0001, 1'b1, 1'b1, 0, CD + 1, "t4");
    bus.ABORT = 1'b1;
    idle_checks(1, "t4_abort_tc");
    bus.ABORT = 1'b0;
    bus.REQ   = '0;
    idle_checks(5, "t4_after");

    // 5: ENABLE gates grants and aborts the countdown
    do_reset("t5_rst");
    bus.ENABLE  = 1'b0;
    bus.REQ_IMG = 8'b11_11_11_01;
    bus.REQ     = 4'b0001;
    idle_checks(10, "t5_blocked");
    bus.ENABLE = 1'b1;
    follow(4'b0001, 1'b0, 1'b1, 0, 5, "t5");
    bus.ENABLE = 1'b0;
    idle_checks(3, "t5_disable");

    // 6: asynchronous reset in the middle of the BOOT pulse
    do_reset("t6_rst");
    bus.ENABLE  = 1'b1;
    bus.REQ_IMG = 8'b01_10_11_00;
    bus.REQ     = 4'b0100;
    follow(4'b0100, 1'b1, 1'b0, 0, CD + 3, "t6");
    #2;
    RST_N = 1'b0;
    #1;
    exp_q.push_back('0);
    check("t6_async_rst");
    idle_checks(1, "t6_in_rst");
    RST_N = 1'b1;
    follow(4'b0100, 1'b1, 1'b0, 0, CD + HOLD + 3, "t6_restart");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
